// File: rtl/mac_frame_merge.sv
`default_nettype none
//==========================================================================
// Module   : mac_frame_merge
// Pops one header word, re-serialises its 14 header bytes and then streams
// the frame body into the egress byte FIFO. Control and truncated frames
// are filtered; saturating forwarded/dropped counters are kept.
// Optional : define DROP_BAD_FCS_EN to drain frames whose header has FCS_OK=0.
// Revision : 1.0
//==========================================================================
module mac_frame_merge #(
    parameter int HEADER_DWIDTH = 128,
    parameter int CNT_WIDTH     = 16,
    parameter bit CTRL_PASS     = 1'b0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [HEADER_DWIDTH-1:0] h_fifo_dout,
    input  logic                     h_fifo_empty,
    output logic                     h_fifo_rden,
    input  logic [7:0]               b_fifo_dout,
    input  logic                     b_fifo_del,
    input  logic                     b_fifo_empty,
    output logic                     b_fifo_rden,
    output logic [7:0]               o_fifo_din,
    output logic                     o_fifo_del,
    output logic                     o_fifo_wren,
    input  logic                     o_fifo_afull,
    output logic [CNT_WIDTH-1:0]     frame_cnt,
    output logic [CNT_WIDTH-1:0]     drop_cnt,
    output logic                     busy
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_HDR   = 3'd1;
    localparam logic [2:0] S_BODY  = 3'd2;
    localparam logic [2:0] S_DRAIN = 3'd3;
    localparam logic [2:0] S_END   = 3'd4;

    localparam logic [3:0] C_LAST_HDR_BYTE = 4'd13;

    logic [2:0]           state_q, state_d;
    logic [111:0]         hdr_q, hdr_d;
    logic [3:0]           cnt_q, cnt_d;
    logic                 fwd_q, fwd_d;
    logic                 drop_q, drop_d;
    logic [CNT_WIDTH-1:0] frame_cnt_q, frame_cnt_d;
    logic [CNT_WIDTH-1:0] drop_cnt_q, drop_cnt_d;

    logic       w_h_rden;
    logic       w_b_rden;
    logic       w_wren;
    logic       w_del;
    logic [7:0] w_din;
    logic       w_bad_fcs;
    logic       w_unused_bits;

`ifdef DROP_BAD_FCS_EN
    assign w_bad_fcs     = ~h_fifo_dout[115];
    assign w_unused_bits = ^{h_fifo_dout[HEADER_DWIDTH-1:117], h_fifo_dout[113:112]};
`else
    assign w_bad_fcs     = 1'b0;
    assign w_unused_bits = ^{h_fifo_dout[HEADER_DWIDTH-1:117], h_fifo_dout[115],
                             h_fifo_dout[113:112]};
`endif

    always_comb begin
        state_d  = state_q;
        hdr_d    = hdr_q;
        cnt_d    = cnt_q;
        fwd_d    = fwd_q;
        drop_d   = drop_q;
        w_h_rden = 1'b0;
        w_b_rden = 1'b0;
        w_wren   = 1'b0;
        w_del    = 1'b0;
        w_din    = 8'h00;
        case (state_q)
            S_IDLE: begin
                if (!h_fifo_empty) begin
                    w_h_rden = 1'b1;
                    hdr_d    = h_fifo_dout[111:0];
                    cnt_d    = 4'd0;
                    fwd_d    = 1'b0;
                    drop_d   = 1'b0;
                    if (h_fifo_dout[116]) begin
                        // Header-only frame: nothing of it sits in the body FIFO
                        state_d = S_END;
                        drop_d  = 1'b1;
                    end else if (h_fifo_dout[114] && !CTRL_PASS) begin
                        state_d = S_DRAIN;
                    end else if (w_bad_fcs) begin
                        state_d = S_DRAIN;
                    end else begin
                        state_d = S_HDR;
                    end
                end
            end
            S_HDR: begin
                if (!o_fifo_afull) begin
                    w_wren = 1'b1;
                    w_din  = hdr_q[111:104];
                    hdr_d  = {hdr_q[103:0], 8'h00};
                    cnt_d  = cnt_q + 4'd1;
                    if (cnt_q == C_LAST_HDR_BYTE) begin
                        state_d = S_BODY;
                    end
                end
            end
            S_BODY: begin
                if (!b_fifo_empty && !o_fifo_afull) begin
                    w_b_rden = 1'b1;
                    w_wren   = 1'b1;
                    w_din    = b_fifo_dout;
                    w_del    = b_fifo_del;
                    if (b_fifo_del) begin
                        state_d = S_END;
                        fwd_d   = 1'b1;
                    end
                end
            end
            S_DRAIN: begin
                if (!b_fifo_empty) begin
                    w_b_rden = 1'b1;
                    if (b_fifo_del) begin
                        state_d = S_END;
                        drop_d  = 1'b1;
                    end
                end
            end
            S_END: begin
                state_d = S_IDLE;
                fwd_d   = 1'b0;
                drop_d  = 1'b0;
            end
            default: begin
                // Recover through S_END without touching either counter
                state_d = S_END;
                fwd_d   = 1'b0;
                drop_d  = 1'b0;
            end
        endcase
    end

    always_comb begin
        frame_cnt_d = frame_cnt_q;
        drop_cnt_d  = drop_cnt_q;
        if (state_q == S_END) begin
            if (fwd_q && !(&frame_cnt_q)) begin
                frame_cnt_d = frame_cnt_q + 1'b1;
            end
            if (drop_q && !(&drop_cnt_q)) begin
                drop_cnt_d = drop_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            hdr_q       <= '0;
            cnt_q       <= 4'd0;
            fwd_q       <= 1'b0;
            drop_q      <= 1'b0;
            frame_cnt_q <= '0;
            drop_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            hdr_q       <= hdr_d;
            cnt_q       <= cnt_d;
            fwd_q       <= fwd_d;
            drop_q      <= drop_d;
            frame_cnt_q <= frame_cnt_d;
            drop_cnt_q  <= drop_cnt_d;
        end
    end

    // Strobes are masked while rst is high so a mid-frame reset emits nothing
    assign h_fifo_rden = w_h_rden & ~rst;
    assign b_fifo_rden = w_b_rden & ~rst;
    assign o_fifo_wren = w_wren & ~rst;
    assign o_fifo_din  = o_fifo_wren ? w_din : 8'h00;
    assign o_fifo_del  = o_fifo_wren & w_del;
    assign busy        = (state_q != S_IDLE) & ~rst;
    assign frame_cnt   = frame_cnt_q;
    assign drop_cnt    = drop_cnt_q;

endmodule
`default_nettype wire
